// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the CPU's inst/data channels, the arbiter and the unified SRAM.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_wen, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output inst_req, inst_wen, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-channel (inst/data) arbiter for one single-ported synchronous SRAM.
// Data wins ties unless inst has been denied MAX_WAIT consecutive cycles.
module sram_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_port_arbiter_if.slave    bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic       grant_inst;
  logic       grant_data;
  logic [1:0] owner_reg;
  logic [1:0] owner_next;
  logic [7:0] starve_cnt_reg;
  logic [7:0] starve_cnt_next;

  // Grant is purely combinational so addr_ok tracks live requests even in reset.
  always_comb begin
    grant_inst = bus.inst_req && (!bus.data_req || (starve_cnt_reg == WAIT_LIMIT));
    grant_data = bus.data_req && !grant_inst;
  end

  always_comb begin
    bus.inst_addr_ok = grant_inst;
    bus.data_addr_ok = grant_data;
    bus.mem_en       = grant_inst || grant_data;
    bus.mem_wen      = 4'h0;
    bus.mem_addr     = 32'h0;
    bus.mem_wdata    = 32'h0;
    if (grant_data) begin
      bus.mem_wen   = bus.data_wen;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end else if (grant_inst) begin
      bus.mem_wen   = bus.inst_wen;
      bus.mem_addr  = bus.inst_addr;
      bus.mem_wdata = bus.inst_wdata;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (grant_data) begin
      owner_next = OWN_DATA;
    end else if (grant_inst) begin
      owner_next = OWN_INST;
    end
  end

  // Counter saturates so a long data burst cannot wrap past the priority point.
  always_comb begin
    starve_cnt_next = 8'h0;
    if (bus.inst_req && !grant_inst) begin
      if (starve_cnt_reg == WAIT_LIMIT) begin
        starve_cnt_next = starve_cnt_reg;
      end else begin
        starve_cnt_next = starve_cnt_reg + 8'h1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= 8'h0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    bus.inst_data_ok = (owner_reg == OWN_INST);
    bus.data_data_ok = (owner_reg == OWN_DATA);
    bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : 32'h0;
    bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a table of single-cycle vectors plus
// hand sequences for reset, starvation, MAX_WAIT=0 and mid-operation reset.
module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  sram_port_arbiter_if bus ();
  sram_port_arbiter_if bus_z ();

  sram_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance sees the same requests but gives inst permanent priority.
  sram_port_arbiter #(.MAX_WAIT(0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  assign bus_z.inst_req   = bus.inst_req;
  assign bus_z.inst_wen   = bus.inst_wen;
  assign bus_z.inst_addr  = bus.inst_addr;
  assign bus_z.inst_wdata = bus.inst_wdata;
  assign bus_z.data_req   = bus.data_req;
  assign bus_z.data_wen   = bus.data_wen;
  assign bus_z.data_addr  = bus.data_addr;
  assign bus_z.data_wdata = bus.data_wdata;
  assign bus_z.mem_rdata  = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed SRAM model with one-cycle registered read.
  logic [31:0] mem [0:255];
  logic [31:0] rd_reg;
  logic [7:0]  mem_idx;
  assign mem_idx       = bus.mem_addr[9:2];
  assign bus.mem_rdata = rd_reg;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 16'h1234};
    rd_reg = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      rd_reg <= mem[mem_idx];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wen[b]) mem[mem_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    string       name;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_iaok;
    logic        e_daok;
    logic [3:0]  e_mwen;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_idok;
    logic [31:0] e_irdata;
    logic        e_ddok;
    logic [31:0] e_drdata;
    logic        chk_drd;
  } vec_t;

  vec_t vecs [0:11];

  function automatic vec_t mk(string name, logic ireq, logic [31:0] iaddr,
                              logic dreq, logic [3:0] dwen, logic [31:0] daddr,
                              logic [31:0] dwdata, logic e_iaok, logic e_daok,
                              logic [3:0] e_mwen, logic [31:0] e_maddr,
                              logic [31:0] e_mwdata, logic e_idok,
                              logic [31:0] e_irdata, logic e_ddok,
                              logic [31:0] e_drdata, logic chk_drd);
    vec_t v;
    v.name = name;     v.ireq = ireq;       v.iaddr = iaddr;
    v.dreq = dreq;     v.dwen = dwen;       v.daddr = daddr;
    v.dwdata = dwdata; v.e_iaok = e_iaok;   v.e_daok = e_daok;
    v.e_mwen = e_mwen; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_idok = e_idok; v.e_irdata = e_irdata;
    v.e_ddok = e_ddok; v.e_drdata = e_drdata; v.chk_drd = chk_drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic [3:0] dwen, input logic [31:0] daddr,
                       input logic [31:0] dwdata);
    bus.inst_req   = ireq;
    bus.inst_wen   = 4'h0;
    bus.inst_addr  = iaddr;
    bus.inst_wdata = 32'h0;
    bus.data_req   = dreq;
    bus.data_wen   = dwen;
    bus.data_addr  = daddr;
    bus.data_wdata = dwdata;
  endtask

  localparam logic [31:0] IA0 = 32'h0040_0000;
  localparam logic [31:0] IA2 = 32'h0040_0008;
  localparam logic [31:0] DA1 = 32'h1001_0004;
  localparam logic [31:0] DA3 = 32'h1001_000C;

  // Grant pattern for ten contended cycles at MAX_WAIT=4 (1 = data wins).
  logic [9:0] starve_pat;

  initial begin
    tests  = 0;
    failed = 0;
    starve_pat = 10'b0111101111;

    //               name            ireq iaddr dreq wen  daddr  wdata         iaok daok mwen maddr  mwdata        idok irdata        ddok drdata        chk
    vecs[0]  = mk("rst_rd_inst",     1,   IA0,  0,   4'h0, 32'h0, 32'h0,        1,   0,   4'h0, IA0,  32'h0,        0,   32'h0,        0,   32'h0,        1);
    vecs[1]  = mk("rst_rd_done",     0,   IA0,  0,   4'h0, 32'h0, 32'h0,        0,   0,   4'h0, 32'h0,32'h0,        1,   32'hC0001234, 0,   32'h0,        1);
    vecs[2]  = mk("tie_data_wins",   1,   IA2,  1,   4'h0, DA3,   32'h0,        0,   1,   4'h0, DA3,  32'h0,        0,   32'h0,        0,   32'h0,        1);
    vecs[3]  = mk("tie_inst_next",   1,   IA2,  0,   4'h0, DA3,   32'h0,        1,   0,   4'h0, IA2,  32'h0,        0,   32'h0,        1,   32'hC0031234, 1);
    vecs[4]  = mk("write",           0,   IA2,  1,   4'h3, DA1,   32'hDEADBEEF, 0,   1,   4'h3, DA1,  32'hDEADBEEF, 1,   32'hC0021234, 0,   32'h0,        1);
    vecs[5]  = mk("read_back",       0,   IA2,  1,   4'h0, DA1,   32'h0,        0,   1,   4'h0, DA1,  32'h0,        0,   32'h0,        1,   32'h0,        0);
    vecs[6]  = mk("read_back_done",  0,   IA2,  0,   4'h0, DA1,   32'h0,        0,   0,   4'h0, 32'h0,32'h0,        0,   32'h0,        1,   32'hC001BEEF, 1);
    vecs[7]  = mk("b2b_inst0",       1,   IA0,  0,   4'h0, DA1,   32'h0,        1,   0,   4'h0, IA0,  32'h0,        0,   32'h0,        0,   32'h0,        1);
    vecs[8]  = mk("b2b_data1",       0,   IA0,  1,   4'h0, DA1,   32'h0,        0,   1,   4'h0, DA1,  32'h0,        1,   32'hC0001234, 0,   32'h0,        1);
    vecs[9]  = mk("b2b_inst2",       1,   IA2,  0,   4'h0, DA1,   32'h0,        1,   0,   4'h0, IA2,  32'h0,        0,   32'h0,        1,   32'hC001BEEF, 1);
    vecs[10] = mk("b2b_data3",       0,   IA2,  1,   4'h0, DA3,   32'h0,        0,   1,   4'h0, DA3,  32'h0,        1,   32'hC0021234, 0,   32'h0,        1);
    vecs[11] = mk("b2b_idle",        0,   IA2,  0,   4'h0, DA3,   32'h0,        0,   0,   4'h0, 32'h0,32'h0,        0,   32'h0,        1,   32'hC0031234, 1);

    // Reset held with both channels requesting.
    rst = 1'b1;
    drive(1, IA0, 1, 4'h0, DA3, 32'h0);
    @(negedge clk); #1;
    chk("reset_inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
    chk("reset_data_data_ok", 32'(bus.data_data_ok), 32'h0);
    chk("reset_inst_rdata",   bus.inst_rdata, 32'h0);
    chk("reset_data_rdata",   bus.data_rdata, 32'h0);
    chk("reset_data_addr_ok", 32'(bus.data_addr_ok), 32'h1);
    chk("reset_inst_addr_ok", 32'(bus.inst_addr_ok), 32'h0);
    chk("reset_mem_en",       32'(bus.mem_en), 32'h1);
    $display("[TB] reset with both requests checked");

    @(negedge clk);
    rst = 1'b0;
    drive(0, IA0, 0, 4'h0, 32'h0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwen,
            vecs[i].daddr, vecs[i].dwdata);
      #1;
      chk({vecs[i].name, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(vecs[i].e_iaok));
      chk({vecs[i].name, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(vecs[i].e_daok));
      chk({vecs[i].name, ".mem_en"}, 32'(bus.mem_en), 32'(vecs[i].e_iaok | vecs[i].e_daok));
      chk({vecs[i].name, ".mem_wen"}, 32'(bus.mem_wen), 32'(vecs[i].e_mwen));
      chk({vecs[i].name, ".mem_addr"}, bus.mem_addr, vecs[i].e_maddr);
      chk({vecs[i].name, ".mem_wdata"}, bus.mem_wdata, vecs[i].e_mwdata);
      chk({vecs[i].name, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(vecs[i].e_idok));
      chk({vecs[i].name, ".inst_rdata"}, bus.inst_rdata, vecs[i].e_irdata);
      chk({vecs[i].name, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(vecs[i].e_ddok));
      if (vecs[i].chk_drd) chk({vecs[i].name, ".data_rdata"}, bus.data_rdata, vecs[i].e_drdata);
      $display("[TB] vec %0d %s applied", i, vecs[i].name);
    end

    // Starvation: both channels request for ten cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1, IA0, 1, 4'h0, DA3, 32'h0);
      #1;
      chk($sformatf("starve_c%0d.data_addr_ok", c + 1), 32'(bus.data_addr_ok), 32'(starve_pat[c]));
      chk($sformatf("starve_c%0d.inst_addr_ok", c + 1), 32'(bus.inst_addr_ok), 32'(!starve_pat[c]));
      chk($sformatf("wait0_c%0d.inst_addr_ok", c + 1), 32'(bus_z.inst_addr_ok), 32'h1);
      chk($sformatf("wait0_c%0d.data_addr_ok", c + 1), 32'(bus_z.data_addr_ok), 32'h0);
      $display("[TB] contended cycle %0d: data_addr_ok=%0b inst_addr_ok=%0b",
               c + 1, bus.data_addr_ok, bus.inst_addr_ok);
    end

    // Mid-operation reset: the dropped data read must never complete.
    @(negedge clk);
    drive(0, IA0, 1, 4'h0, DA1, 32'h0);
    #1;
    chk("midrst_grant.data_addr_ok", 32'(bus.data_addr_ok), 32'h1);
    @(negedge clk);
    drive(0, IA0, 0, 4'h0, DA1, 32'h0);
    rst = 1'b1;
    #1;
    chk("midrst_pulse.data_data_ok", 32'(bus.data_data_ok), 32'h0);
    chk("midrst_pulse.data_rdata", bus.data_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_after.data_data_ok", 32'(bus.data_data_ok), 32'h0);
    @(negedge clk); #1;
    chk("midrst_after2.data_data_ok", 32'(bus.data_data_ok), 32'h0);
    chk("midrst_after2.inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
    $display("[TB] mid-operation reset sequence applied");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
